interdevice_uart_tx: RTL and testbench
======================================

Name: interdevice_uart_tx

Overview:
Byte-serialising UART transmitter for the interdevice link. It sits directly downstream of the interdevice UART baud-tick generator and consumes its one-cycle `uart_clk_out` pulse as the bit-period strobe. It accepts frames from the interdevice controller over a valid/ready handshake and drives the TX pin as start, data (LSB first), optional parity, then stop bit(s).

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock (CPU_CLK).
- rst_n  input  1  synchronous, active-low reset.
- uart_clk_in  input  1  bit-period tick; 1-cycle pulse from the baud generator, once per bit period.
- tx_data  input  DATA_BITS  frame payload; sampled only on an accept cycle.
- tx_valid  input  1  payload valid.
- tx_ready  output  1  block can accept a payload this cycle.
- uart_tx  output  1  serial line out; idles high; registered.
- busy  output  1  a frame is in flight (state != IDLE).

Behaviour:
- Reset and clocking:
  - One clock (`clk`). Reset is synchronous and active-low (`rst_n`), sampled on posedge clk.
  - Reset values: state=IDLE, uart_tx=1, tx_ready=1, busy=0, shift register=0, counters=0.
- Handshake:
  - tx_ready = (state==IDLE), combinational from the state register.
  - Accept occurs when tx_valid && tx_ready at a posedge. On accept: tx_data is latched into the shift register, parity is precomputed, state moves to ARMED.
  - After accept, tx_data is don't-care until the next accept.
  - tx_valid held while tx_ready=0 has no effect; the payload must be held by the producer.
- States: IDLE, ARMED, START, DATA, PARITY, STOP. Transitions and uart_tx updates occur only on cycles where uart_clk_in=1, except IDLE->ARMED.
  - ARMED: holds uart_tx=1. On tick: uart_tx<=0, go to START.
    - A tick in the accept cycle itself is ignored; the start bit begins on the first tick strictly after the accept.
  - START: on tick: uart_tx<=shift[0], bit_cnt<=0, shift right, go to DATA.
  - DATA: on tick:
    - If bit_cnt==DATA_BITS-1: if PARITY_EN, uart_tx<=parity and go to PARITY; otherwise uart_tx<=1, stop_cnt<=0, go to STOP.
    - Otherwise: uart_tx<=shift[0], shift right, bit_cnt+1.
  - PARITY: on tick: uart_tx<=1, stop_cnt<=0, go to STOP.
  - STOP: on tick:
    - If stop_cnt==STOP_BITS-1: go to IDLE; uart_tx stays 1.
    - Otherwise: stop_cnt+1.
- Bit timing: every bit, including each stop bit, lasts exactly one tick interval; line edges are registered one clk after the tick cycle.
- Parity: even = XOR of the DATA_BITS payload bits; odd = inverted XOR.
- Back-to-back frames: the line stays high between frames. The gap from the end of the stop bit(s) to the next start bit is at least one tick interval, because of the ARMED wait. No frame is ever dropped or merged.
- Tick absent: the FSM holds its state indefinitely and uart_tx holds its value.
- Reset mid-frame: on the next posedge, uart_tx=1 and state=IDLE. The in-flight frame is discarded and no partial stop bit is emitted.
- bit_cnt width: $clog2(DATA_BITS). No wrap beyond DATA_BITS-1.

Test Plan:
- Reset, then tick every 4 clk, 8N1. Send 0xA5 -> uart_tx sequence per tick = 0,1,0,1,0,0,1,0,1,1. tx_ready=0 from the accept cycle until the final stop tick; busy mirrors it; line returns high.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0 between data bit 7 and stop. PARITY_ODD=1 -> parity bit 1. 0x07 with even parity -> parity bit 1.
- STOP_BITS=2, tx_valid held high with 0x55 then 0x0F -> two full stop-bit intervals high, at least one further idle tick before the second start bit. Second frame bits = 1,1,1,1,0,0,0,0. Both frames intact.
- Tick asserted in the same cycle as the accept -> no start bit on that tick; start bit appears on the next tick. Change tx_data mid-frame -> transmitted bits unchanged.
- Assert rst_n=0 for 1 cycle during data bit 3 of 0x00 -> uart_tx=1, tx_ready=1, busy=0 the next cycle. A subsequent 0xFF sends a clean frame.
- Stop ticks for 50 clk mid-DATA -> uart_tx and state frozen; on resume, the remaining bits are emitted with correct order and count.

Source files
------------

// File: rtl/interdevice_uart_tx.sv
// Interdevice UART transmitter: serialises one payload per valid/ready handshake
// as start, LSB-first data, optional parity and stop bit(s), paced by the
// one-cycle bit-period tick from the baud generator.
module interdevice_uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_clk_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   stop_cnt;

    // Handshake and activity flags decode straight from the state register.
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Frame FSM; every line change after acceptance waits for a bit tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_tx  <= 1'b1;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick coinciding with the accept is deliberately not used.
                    if (tx_valid) begin
                        shift_q  <= tx_data;
                        parity_q <= (^tx_data) ^ (PARITY_ODD != 0);
                        state    <= ARMED;
                    end
                end
                ARMED: begin
                    if (uart_clk_in) begin
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (uart_clk_in) begin
                        uart_tx <= shift_q[0];
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (uart_clk_in) begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                uart_tx <= parity_q;
                                state   <= PARITY;
                            end else begin
                                uart_tx  <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            uart_tx <= shift_q[0];
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (uart_clk_in) begin
                        uart_tx  <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (uart_clk_in) begin
                        if (stop_cnt == LAST_STOP) begin
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    uart_tx <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interdevice_uart_tx.sv
// Bench for interdevice_uart_tx: four configurations (8N1, 8E1, 8O1, 8N2) share
// clock, reset and tick; a line monitor decodes frames per tick and checks them
// against frames queued at accept time.
module tb_interdevice_uart_tx;

    localparam int NI = 4;

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          n;
    } frame_t;

    int pe_t [NI] = '{0, 1, 1, 0};
    int po_t [NI] = '{0, 0, 1, 0};
    int sb_t [NI] = '{1, 1, 1, 2};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick_en;
    logic [31:0] cyc = 32'd0;
    logic        tick;
    logic [7:0]  tx_data;
    logic        valid [NI];
    logic        ready [NI];
    logic        line  [NI];
    logic        busy  [NI];

    int n_tests = 0;
    int n_fail  = 0;

    frame_t      exp_q[$];
    bit          mon_active [NI];
    logic [15:0] cur_bits   [NI];
    int          cur_n      [NI];
    int          pos        [NI];
    int          idle_cnt   [NI];
    logic        last       [NI];

    always #5 clk = ~clk;

    // Tick every 4 clocks while enabled; cyc phase lets tests align to a tick.
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign tick = tick_en && (cyc[1:0] == 2'd0);

    interdevice_uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .uart_clk_in(tick), .tx_data(tx_data),
        .tx_valid(valid[0]), .tx_ready(ready[0]), .uart_tx(line[0]), .busy(busy[0]));
    interdevice_uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .uart_clk_in(tick), .tx_data(tx_data),
        .tx_valid(valid[1]), .tx_ready(ready[1]), .uart_tx(line[1]), .busy(busy[1]));
    interdevice_uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .uart_clk_in(tick), .tx_data(tx_data),
        .tx_valid(valid[2]), .tx_ready(ready[2]), .uart_tx(line[2]), .busy(busy[2]));
    interdevice_uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .uart_clk_in(tick), .tx_data(tx_data),
        .tx_valid(valid[3]), .tx_ready(ready[3]), .uart_tx(line[3]), .busy(busy[3]));

    // Line monitor: holds between ticks, start detection, per-tick frame bits, inter-frame gap.
    always @(posedge clk) begin
        logic   t;
        logic   r;
        frame_t f;
        t = tick;
        r = rst_n;
        #1;
        for (int i = 0; i < NI; i++) begin
            if (!r) begin
                n_tests++;
                if (line[i] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_line_%0d: uart_tx=%b, required 1", i, line[i]);
                end
                mon_active[i] = 1'b0;
                idle_cnt[i]   = 1;
                last[i]       = 1'b1;
            end else begin
                if (!t) begin
                    n_tests++;
                    if (line[i] !== last[i]) begin
                        n_fail++;
                        $display("FAIL hold_%0d: uart_tx=%b without tick, required %b", i, line[i], last[i]);
                    end
                end else if (mon_active[i]) begin
                    n_tests++;
                    if (line[i] !== cur_bits[i][pos[i]]) begin
                        n_fail++;
                        $display("FAIL frame_bit_%0d_pos%0d: uart_tx=%b, required %b", i, pos[i], line[i], cur_bits[i][pos[i]]);
                    end
                    pos[i]++;
                    if (pos[i] == cur_n[i]) begin
                        mon_active[i] = 1'b0;
                        idle_cnt[i]   = 0;
                    end
                end else if (line[i] === 1'b0) begin
                    n_tests++;
                    if (exp_q.size() == 0 || exp_q[0].inst != i) begin
                        n_fail++;
                        $display("FAIL spurious_start_%0d: start bit seen, required idle line (queued %0d)", i, exp_q.size());
                    end else begin
                        f = exp_q.pop_front();
                        cur_bits[i]   = f.bits;
                        cur_n[i]      = f.n;
                        pos[i]        = 1;
                        mon_active[i] = 1'b1;
                        n_tests++;
                        if (idle_cnt[i] < 1) begin
                            n_fail++;
                            $display("FAIL gap_%0d: %0d idle ticks before start, required >= 1", i, idle_cnt[i]);
                        end
                    end
                end else begin
                    idle_cnt[i]++;
                end
                last[i] = line[i];
            end
        end
    end

    // Expected per-tick line values for one frame, starting with the start bit.
    task automatic push_frame(input int i, input logic [7:0] d);
        frame_t f;
        int     ones;
        int     k;
        f.inst = i;
        f.bits = '1;
        f.bits[0] = 1'b0;
        ones = 0;
        for (int b = 0; b < 8; b++) begin
            f.bits[1+b] = d[b];
            if (d[b]) ones++;
        end
        k = 9;
        if (pe_t[i] != 0) begin
            f.bits[k] = ((ones % 2) == 1) ? (po_t[i] == 0) : (po_t[i] != 0);
            k++;
        end
        for (int s = 0; s < sb_t[i]; s++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        exp_q.push_back(f);
    endtask

    function automatic int pending(input int i);
        int c = 0;
        foreach (exp_q[j]) if (exp_q[j].inst == i) c++;
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the accept with tx_valid still high.
    task automatic send(input int i, input logic [7:0] d);
        int k = 0;
        tx_data  = d;
        valid[i] = 1'b1;
        while (!ready[i] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!ready[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout_%0d: tx_ready=%b after %0d cycles, required 1", i, ready[i], k);
            valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        push_frame(i, d);
        @(negedge clk);
    endtask

    task automatic wait_done(input int i);
        int k = 0;
        while ((mon_active[i] || pending(i) != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (mon_active[i] || pending(i) != 0) begin
            n_fail++;
            $display("FAIL frame_timeout_%0d: %0d frames still pending, required 0", i, pending(i));
        end
    endtask

    task automatic check_idle_flags(input string tag);
        for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (ready[i] !== 1'b1 || busy[i] !== 1'b0 || line[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_%0d: ready=%b busy=%b uart_tx=%b, required 1 0 1", tag, i, ready[i], busy[i], line[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tick_en = 1'b1;
        tx_data = 8'h00;
        for (int i = 0; i < NI; i++) valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_flags("reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_idle_flags("post_reset");
    endtask

    task automatic test_basic_8n1();
        send(0, 8'hA5);
        valid[0] = 1'b0;
        n_tests++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_in_flight: ready=%b busy=%b, required 0 1", ready[0], busy[0]);
        end
        wait_done(0);
        n_tests++;
        if (ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_stop_bit: ready=%b busy=%b, required 0 1", ready[0], busy[0]);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || line[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: ready=%b busy=%b uart_tx=%b, required 1 0 1", ready[0], busy[0], line[0]);
        end
    endtask

    task automatic test_parity();
        send(1, 8'hA5); valid[1] = 1'b0; wait_done(1);
        send(2, 8'hA5); valid[2] = 1'b0; wait_done(2);
        send(1, 8'h07); valid[1] = 1'b0; wait_done(1);
        send(2, 8'h07); valid[2] = 1'b0; wait_done(2);
    endtask

    task automatic test_back_to_back();
        send(3, 8'h55);
        send(3, 8'h0F);
        valid[3] = 1'b0;
        wait_done(3);
    endtask

    task automatic test_same_cycle_tick();
        int k = 0;
        repeat (8) @(negedge clk);
        while (cyc[1:0] != 2'd0 && k < 16) begin
            @(negedge clk);
            k++;
        end
        send(0, 8'h3C);
        valid[0] = 1'b0;
        tx_data  = 8'hC3;
        n_tests++;
        if (line[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_tick_line: uart_tx=%b on accept tick, required 1", line[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (line[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL armed_wait_line: uart_tx=%b before next tick, required 1", line[0]);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (line[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL start_next_tick: uart_tx=%b after next tick, required 0", line[0]);
        end
        @(negedge clk);
        wait_done(0);
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        send(0, 8'h00);
        valid[0] = 1'b0;
        while (!(mon_active[0] && pos[0] == 5) && k < 500) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!(mon_active[0] && pos[0] == 5)) begin
            n_fail++;
            $display("FAIL reach_data_bit3: monitor pos=%0d, required 5", pos[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_flags("mid_frame_reset");
        repeat (8) @(negedge clk);
        send(0, 8'hFF);
        valid[0] = 1'b0;
        wait_done(0);
    endtask

    task automatic test_tick_freeze();
        int   k = 0;
        logic held;
        send(0, 8'h96);
        valid[0] = 1'b0;
        while (!(mon_active[0] && pos[0] == 4) && k < 500) begin
            @(negedge clk);
            k++;
        end
        tick_en = 1'b0;
        held    = line[0];
        repeat (50) @(negedge clk);
        n_tests++;
        if (line[0] !== held || busy[0] !== 1'b1 || !mon_active[0]) begin
            n_fail++;
            $display("FAIL freeze: uart_tx=%b busy=%b, required %b 1", line[0], busy[0], held);
        end
        tick_en = 1'b1;
        wait_done(0);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            valid[i]      = 1'b0;
            mon_active[i] = 1'b0;
            idle_cnt[i]   = 1;
            last[i]       = 1'b1;
            pos[i]        = 0;
            cur_n[i]      = 0;
            cur_bits[i]   = '1;
        end
        test_reset();
        test_basic_8n1();
        test_parity();
        test_back_to_back();
        test_same_cycle_tick();
        test_reset_mid_frame();
        test_tick_freeze();
        repeat (12) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_frames: %0d queued, required 0", exp_q.size());
        end
        check_idle_flags("final");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
